// File: rtl/ramdma_ci_copy.sv
// Custom-instruction scratchpad RAM with a background block-copy engine.
// Define RAMDMA_FILL_EN to add the SETPAT/FILL ops and the pattern register.
module ramdma_ci_copy #(
  parameter logic [7:0]  CUSTOM_ID  = 8'h0F,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);
  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH);

  localparam logic [2:0] OP_READ   = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_SETPTR = 3'd2;
  localparam logic [2:0] OP_COPY   = 3'd3;
  localparam logic [2:0] OP_STATUS = 3'd4;
  localparam logic [2:0] OP_FILL   = 3'd5;
  localparam logic [2:0] OP_SETPAT = 3'd6;

  typedef enum logic [1:0] {IDLE, RD_WAIT, PENDING} ci_state_t;
  typedef enum logic [1:0] {C_IDLE, C_READ, C_WRITE} cp_state_t;

  typedef struct packed {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [31:0]   b;
  } req_t;

  ci_state_t ci_state, ci_next;
  cp_state_t cp_state, cp_next;
  req_t      req, pend;
  logic      accept, req_valid, stallable, stall, exec;
  logic      fill_op, copy_go, fill_go, len_load;
  logic [AW-1:0] src, dst, cp_src, cp_dst, ram_addr;
  logic [LW-1:0] len, idx, req_len, remaining;
  logic          cp_fill, ram_we;
  logic [DW-1:0] rd_data, wr_data, fill_data;
  logic [DW-1:0] mem [DEPTH];
  logic          unused_bits;

  assign accept    = reset && start && (ciN == CUSTOM_ID);
  assign busy      = (cp_state != C_IDLE);
  assign remaining = len - idx;
  assign unused_bits = ^{valueA, valueB};

  // Request source: live bus in IDLE, latched request once the engine frees up.
  always_comb begin
    req.op    = valueA[12:10];
    req.addr  = valueA[AW-1:0];
    req.b     = valueB;
    req_valid = 1'b0;
    unique case (ci_state)
      IDLE:    req_valid = accept;
      PENDING: begin
        req       = pend;
        req_valid = reset && !busy;
      end
      default: req_valid = 1'b0;
    endcase
  end

`ifdef RAMDMA_FILL_EN
  logic [31:0] pattern;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               pattern <= '0;
    else if (exec && (req.op == OP_SETPAT))   pattern <= req.b;
  end

  assign fill_data = pattern[DW-1:0];
  assign fill_op   = exec && (req.op == OP_FILL);
  assign stallable = (req.op == OP_READ) || (req.op == OP_WRITE) ||
                     (req.op == OP_COPY) || (req.op == OP_FILL);
`else
  assign fill_data = '0;
  assign fill_op   = 1'b0;
  assign stallable = (req.op == OP_READ) || (req.op == OP_WRITE) || (req.op == OP_COPY);
`endif

  assign stall    = req_valid && stallable && busy;
  assign exec     = req_valid && !stall;
  assign req_len  = (req.b[AW] && (|req.b[AW-1:0])) ? MAX_LEN : req.b[AW:0];
  assign len_load = (exec && (req.op == OP_COPY)) || fill_op;
  assign copy_go  = exec && (req.op == OP_COPY) && (req_len != '0);
  assign fill_go  = fill_op && (req_len != '0);

  // CI FSM: state register, next state, outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ci_state <= IDLE;
    else        ci_state <= ci_next;
  end

  always_comb begin
    ci_next = ci_state;
    unique case (ci_state)
      IDLE, PENDING: begin
        if (stall)     ci_next = PENDING;
        else if (exec) ci_next = (req.op == OP_READ) ? RD_WAIT : IDLE;
      end
      RD_WAIT: ci_next = IDLE;
      default: ci_next = IDLE;
    endcase
  end

  always_comb begin
    done   = 1'b0;
    result = '0;
    if (ci_state == RD_WAIT) begin
      done   = 1'b1;
      result = 32'(rd_data);
    end else if (exec && (req.op != OP_READ)) begin
      done = 1'b1;
      if (req.op == OP_STATUS) result = {busy, 15'b0, 16'(remaining)};
    end
  end

  // Copy FSM: state register, next state, RAM port control.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cp_state <= C_IDLE;
    else        cp_state <= cp_next;
  end

  always_comb begin
    cp_next = cp_state;
    unique case (cp_state)
      C_IDLE: begin
        if (copy_go)      cp_next = C_READ;
        else if (fill_go) cp_next = C_WRITE;
      end
      C_READ:  cp_next = C_WRITE;
      C_WRITE: begin
        if ((idx + LW'(1)) == len) cp_next = C_IDLE;
        else if (!cp_fill)         cp_next = C_READ;
      end
      default: cp_next = C_IDLE;
    endcase
  end

  always_comb begin
    ram_addr = req.addr;
    ram_we   = exec && (req.op == OP_WRITE);
    wr_data  = req.b[DW-1:0];
    unique case (cp_state)
      C_READ: begin
        ram_addr = cp_src + idx[AW-1:0];
        ram_we   = 1'b0;
      end
      C_WRITE: begin
        ram_addr = cp_dst + idx[AW-1:0];
        ram_we   = 1'b1;
        wr_data  = cp_fill ? fill_data : rd_data;
      end
      default: ;
    endcase
  end

  // Pointer, length and pending-request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      idx     <= '0;
      cp_src  <= '0;
      cp_dst  <= '0;
      cp_fill <= 1'b0;
      pend    <= '0;
    end else begin
      if (stall) pend <= req;
      if (exec && (req.op == OP_SETPTR)) begin
        dst <= req.addr;
        src <= req.b[AW-1:0];
      end
      if (len_load) begin
        len     <= req_len;
        idx     <= '0;
        cp_src  <= src;
        cp_dst  <= dst;
        cp_fill <= fill_op;
      end else if (cp_state == C_WRITE) begin
        idx <= idx + LW'(1);
      end
    end
  end

  // Single-port RAM, contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= wr_data;
    rd_data <= mem[ram_addr];
  end
endmodule
